// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with overlapping/non-overlapping match modes.
// Optional saturating match counter is built when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             detect,
   output logic [CNT_W-1:0] match_count
);
   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);
   typedef enum logic [1:0] {IDLE, HUNT, HIT} state_t;
   state_t state, state_n;
   logic [PAT_W-1:0] pat, pat_n, hist, hist_n, shifted;
   logic [FW-1:0] fill, fill_n, fill_inc;
   logic consume, match;
   assign shifted  = {hist[PAT_W-2:0], in};
   assign fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
   assign consume  = !load && state != IDLE && in_valid;
   assign match    = consume && shifted == pat && fill_inc == FULL;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         pat    <= '0;
         hist   <= '0;
         fill   <= '0;
         detect <= 1'b0;
      end else begin
         state  <= state_n;
         pat    <= pat_n;
         hist   <= hist_n;
         fill   <= fill_n;
         detect <= state_n == HIT;
      end
   end
   always_comb begin
      state_n = state;
      pat_n   = pat;
      hist_n  = hist;
      fill_n  = fill;
      if (load) begin
         state_n = HUNT;
         pat_n   = pattern;
         hist_n  = '0;
         fill_n  = '0;
      end else if (consume) begin
         state_n = match ? HIT : HUNT;
         hist_n  = shifted;
         // non-overlap restarts the fill so the next match needs PAT_W fresh bits
         fill_n  = (match && !overlap) ? '0 : fill_inc;
      end else if (state == HIT) begin
         state_n = HUNT;
      end
   end
`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '0;
      else if (match && !(&cnt)) cnt <= cnt + 1'b1;
   end
   assign match_count = cnt;
`else
   assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized + directed bench against a queue-based reference model.
module tb_seq_detector_param;
   logic clk = 1'b0, rst = 1'b0, din = 1'b0, iv = 1'b0, ld = 1'b0, ov = 1'b0;
   logic [3:0] pat = '0;
   logic det8, det2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   int checks = 0, failures = 0;
   bit armed = 0;
   logic [3:0] mpat = '0;
   bit q[$];
   bit exp_det = 0;
   int c8 = 0, c2 = 0;

   seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .in(din), .in_valid(iv), .load(ld), .pattern(pat),
      .overlap(ov), .detect(det8), .match_count(cnt8));
   seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in(din), .in_valid(iv), .load(ld), .pattern(pat),
      .overlap(ov), .detect(det2), .match_count(cnt2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ec(input int c);
`ifdef SEQDET_COUNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".det8"}, {31'b0, det8}, {31'b0, exp_det});
      check({tag, ".det2"}, {31'b0, det2}, {31'b0, exp_det});
      check({tag, ".cnt8"}, {24'b0, cnt8}, ec(c8));
      check({tag, ".cnt2"}, {30'b0, cnt2}, ec(c2));
   endtask

   task automatic model_reset();
      armed = 0;
      mpat = '0;
      q.delete();
      exp_det = 0;
      c8 = 0;
      c2 = 0;
   endtask

   // one clock: drive inputs, advance the model on the edge, check 1 time unit later
   task automatic step(input string tag, input logic b, input logic v, input logic l,
                       input logic o, input logic [3:0] p);
      din = b; iv = v; ld = l; ov = o; pat = p;
      @(posedge clk);
      exp_det = 0;
      if (l) begin
         armed = 1;
         mpat = p;
         q.delete();
      end else if (armed && v) begin
         q.push_back(b);
         if (q.size() > 4) void'(q.pop_front());
         if (q.size() == 4 && {q[0], q[1], q[2], q[3]} == mpat) begin
            exp_det = 1;
            if (c8 < 255) c8++;
            if (c2 < 3) c2++;
            if (!o) q.delete();
         end
      end
      #1;
      check_all(tag);
   endtask

   task automatic bits(input string tag, input logic [15:0] seq, input int n, input logic o);
      for (int i = n - 1; i >= 0; i--) step(tag, seq[i], 1'b1, 1'b0, o, 4'b0);
   endtask

   int ndet;

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;
      // non-overlap: one detect after 4th bit
      step("load", 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010);
      bits("nonov", 16'b101010, 6, 1'b0);
      check("nonov.count_dir", {24'b0, cnt8}, ec(1));
      // overlap: detects after bits 4 and 6
      step("load", 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
      bits("ov", 16'b101010, 6, 1'b1);
      check("ov.count_dir", {24'b0, cnt8}, ec(3));
      // gaps with in_valid low are ignored
      step("load", 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010);
      bits("gap", 16'b10, 2, 1'b0);
      for (int i = 0; i < 3; i++) step("gap.idle", i[0], 1'b0, 1'b0, 1'b0, 4'b0);
      bits("gap", 16'b10, 2, 1'b0);
      check("gap.det", {31'b0, det8}, 32'd1);
      // CNT_W=2 saturation: five detects
      step("load", 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
      ndet = 0;
      for (int i = 0; i < 12; i++) begin
         step("sat", ~i[0], 1'b1, 1'b0, 1'b1, 4'b0);
         ndet += det2;
      end
      check("sat.ndet", ndet, 5);
      check("sat.cnt2", {30'b0, cnt2}, ec(3));
      // async reset while detect is high
      step("load", 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010);
      bits("pre_rst", 16'b1010, 4, 1'b0);
      check("pre_rst.det", {31'b0, det8}, 32'd1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #2 rst = 1'b1;
      bits("idle", 16'b1010, 4, 1'b0);
      // reload discards prior bits
      step("load", 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
      bits("reload.pre", 16'b111, 3, 1'b1);
      step("reload", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
      bits("reload.ones", 16'b111, 3, 1'b1);
      step("reload.m1", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0);
      check("reload.m1.det", {31'b0, det8}, 32'd1);
      step("reload.m2", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0);
      check("reload.m2.det", {31'b0, det8}, 32'd1);
      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) ov = ~ov;
         step("rand", 1'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 47) == 0,
              ov, 4'($urandom));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
